pipeline_skid_reg: RTL and testbench
====================================

PIPELINE_SKID_REG -- requirements
Module: pipeline_skid_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 64, payload width in bits (e.g. 32-bit addr + 32-bit inst); legal range 1..1024.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port flush  input  1  discard all held entries.
REQ-005 SHALL have port in_valid  input  1  upstream offers in_data.
REQ-006 SHALL have port in_ready  output  1  stage accepts in_data this cycle.
REQ-007 SHALL have port in_data  input  WIDTH  upstream payload.
REQ-008 SHALL have port out_valid  output  1  out_data valid.
REQ-009 SHALL have port out_ready  input  1  downstream accepts out_data.
REQ-010 SHALL have port out_data  output  WIDTH  payload to downstream.

Function
REQ-011 SHALL hold two WIDTH-bit registers: main (drives out_data) and skid; state EMPTY (0 entries), BUSY (main full), FULL (main + skid full).
REQ-012 SHALL drive out_valid = (state != EMPTY) and in_ready = (state != FULL), both decoded from registered state only; no combinational in->out path.
REQ-013 SHALL define in_fire = in_valid & in_ready and out_fire = out_valid & out_ready.
REQ-014 SHALL transition EMPTY: in_fire -> BUSY, main <= in_data; else stay.
REQ-015 SHALL transition BUSY: in_fire & out_fire -> BUSY, main <= in_data; in_fire only -> FULL, skid <= in_data; out_fire only -> EMPTY; neither -> stay.
REQ-016 SHALL transition FULL: out_fire -> BUSY, main <= skid; else stay (in_fire impossible).
REQ-017 SHALL provide 1-cycle latency (accepted at edge N, visible on out_data after edge N) and sustain one transfer per cycle while out_ready is high.
REQ-018 SHALL preserve order and never drop or duplicate an accepted entry except by flush/rst.
REQ-019 SHALL, on flush, go to EMPTY and zero main and skid at the next edge, regardless of in_fire/out_fire; an in_fire that cycle is discarded.
REQ-020 SHALL keep out_data stable while out_valid & !out_ready.
REQ-021 SHALL give rst priority over flush, and flush priority over all handshakes.

Reset
REQ-022 SHALL, on rst high at a clock edge, set state EMPTY, main = 0, skid = 0; so out_valid = 0, in_ready = 1, out_data = 0.
REQ-023 SHALL, on rst asserted mid-transfer (BUSY or FULL), discard all entries identically to REQ-022.

Configuration
REQ-024 SHALL, when macro PIPELINE_SKID_REG_STATS_EN is defined, add output stall_cycles (16 bits) counting cycles with out_valid & !out_ready, saturating at 0xFFFF, cleared by rst only (not by flush).
REQ-025 SHALL, when PIPELINE_SKID_REG_STATS_EN is undefined, omit the stall_cycles port and counter; all other behaviour identical.

Verification
REQ-026 SHALL cover reset: rst=1 one edge with prior FULL state -> out_valid=0, in_ready=1, out_data=0.
REQ-027 SHALL cover streaming: WIDTH=64, out_ready=1, in_valid=1 with data 1,2,3,4 on consecutive cycles -> out_data 1,2,3,4 one cycle later each, in_ready stays 1.
REQ-028 SHALL cover backpressure: send 0xA then 0xB with out_ready=0 -> state FULL, in_ready=0, out_data=0xA held; raise out_ready -> 0xA, then 0xB output; in_ready=1 one cycle after the first out_fire.
REQ-029 SHALL cover flush in FULL with simultaneous in_valid=1 data 0xC -> next cycle out_valid=0, in_ready=1, out_data=0, 0xC never appears.
REQ-030 SHALL cover stats (macro defined): out_valid=1, out_ready=0 for 70000 cycles -> stall_cycles=0xFFFF; flush leaves it 0xFFFF; rst -> 0.
REQ-031 SHALL cover random valid/ready: 10000 cycles against a scoreboard -> output sequence equals accepted input sequence, no loss or duplication.

Source files
------------

// File: rtl/pipeline_skid_reg.sv
// pipeline_skid_reg
// Two-entry ready/valid pipeline stage. The main register drives out_data;
// a skid register catches the one beat that can arrive in the cycle the
// downstream stalls, so in_ready is a pure register decode and the stage
// has no combinational path from the input side to the output side.
//
// Parameters:
//   WIDTH        payload width in bits (1..1024)
// Ports:
//   clk          sole clock, rising edge
//   rst          synchronous active-high reset (priority over flush)
//   flush        drop all held entries at the next edge
//   in_valid     upstream offers in_data
//   in_ready     stage can accept in_data this cycle
//   in_data      upstream payload
//   out_valid    out_data holds a valid entry
//   out_ready    downstream accepts out_data
//   out_data     payload to downstream
//   stall_cycles (only with PIPELINE_SKID_REG_STATS_EN) saturating count of
//                cycles with out_valid & !out_ready, cleared by rst only
//
// Optional feature macro: PIPELINE_SKID_REG_STATS_EN
//
// state    | meaning
// ---------+-------------------------------------------
// ST_EMPTY | no entries held
// ST_BUSY  | main holds one entry
// ST_FULL  | main holds oldest entry, skid holds next

module pipeline_skid_reg #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef PIPELINE_SKID_REG_STATS_EN
  ,
  output logic [15:0]      stall_cycles
`endif
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;

  logic w_in_fire;
  logic w_out_fire;

  assign out_valid  = (r_state != ST_EMPTY);
  assign in_ready   = (r_state != ST_FULL);
  assign out_data   = r_main;
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_state <= ST_EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            r_state <= ST_BUSY;
            r_main  <= in_data;
          end
        end
        ST_BUSY: begin
          if (w_in_fire && w_out_fire) begin
            r_main <= in_data;
          end else if (w_in_fire) begin
            r_state <= ST_FULL;
            r_skid  <= in_data;
          end else if (w_out_fire) begin
            r_state <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only the drain of main can happen
          if (w_out_fire) begin
            r_state <= ST_BUSY;
            r_main  <= r_skid;
          end
        end
        default: begin
          r_state <= ST_EMPTY;
        end
      endcase
    end
  end

`ifdef PIPELINE_SKID_REG_STATS_EN
  logic [15:0] r_stall_cycles;

  // flush deliberately leaves the count alone; only rst clears it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= '0;
    end else if (out_valid && !out_ready && (r_stall_cycles != 16'hFFFF)) begin
      r_stall_cycles <= r_stall_cycles + 16'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_pipeline_skid_reg.sv
module tb_pipeline_skid_reg;

  localparam int WIDTH = 64;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
`ifdef PIPELINE_SKID_REG_STATS_EN
  logic [15:0]      stall_cycles;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipeline_skid_reg #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef PIPELINE_SKID_REG_STATS_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    step();
    rst = 1'b0;
    n_vec++;
    if ({out_valid, in_ready, out_data} !== {1'b0, 1'b1, 64'd0}) begin
      n_err++;
      $display("FAIL reset_init: got v=%0b r=%0b d=%0h want v=0 r=1 d=0", out_valid, in_ready, out_data);
    end
    in_valid = 1'b1; in_data = 64'h5;
    step();
    in_data = 64'h6;
    step();
    in_valid = 1'b0;
    n_vec++;
    if ({out_valid, in_ready, out_data} !== {1'b1, 1'b0, 64'h5}) begin
      n_err++;
      $display("FAIL reset_prefill: got v=%0b r=%0b d=%0h want v=1 r=0 d=5", out_valid, in_ready, out_data);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_vec++;
    if ({out_valid, in_ready, out_data} !== {1'b0, 1'b1, 64'd0}) begin
      n_err++;
      $display("FAIL reset_from_full: got v=%0b r=%0b d=%0h want v=0 r=1 d=0", out_valid, in_ready, out_data);
    end
    out_ready = 1'b1;
    step();
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_skid_gone: got v=%0b want v=0", out_valid);
    end
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_data = 64'(i);
      step();
      n_vec++;
      if ({out_valid, in_ready, out_data} !== {1'b1, 1'b1, 64'(i)}) begin
        n_err++;
        $display("FAIL stream_%0d: got v=%0b r=%0b d=%0h want v=1 r=1 d=%0h", i, out_valid, in_ready, out_data, i);
      end
    end
    in_valid = 1'b0;
    step();
    n_vec++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL stream_drain: got v=%0b r=%0b want v=0 r=1", out_valid, in_ready);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'hA;
    step();
    n_vec++;
    if ({out_valid, in_ready, out_data} !== {1'b1, 1'b1, 64'hA}) begin
      n_err++;
      $display("FAIL bp_first: got v=%0b r=%0b d=%0h want v=1 r=1 d=a", out_valid, in_ready, out_data);
    end
    in_data = 64'hB;
    step();
    in_valid = 1'b0;
    in_data  = 64'hF;
    n_vec++;
    if ({out_valid, in_ready, out_data} !== {1'b1, 1'b0, 64'hA}) begin
      n_err++;
      $display("FAIL bp_full: got v=%0b r=%0b d=%0h want v=1 r=0 d=a", out_valid, in_ready, out_data);
    end
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n_vec++;
    if ({out_valid, in_ready, out_data} !== {1'b1, 1'b0, 64'hA}) begin
      n_err++;
      $display("FAIL bp_hold: got v=%0b r=%0b d=%0h want v=1 r=0 d=a", out_valid, in_ready, out_data);
    end
    out_ready = 1'b1;
    step();
    n_vec++;
    if ({out_valid, in_ready, out_data} !== {1'b1, 1'b1, 64'hB}) begin
      n_err++;
      $display("FAIL bp_second: got v=%0b r=%0b d=%0h want v=1 r=1 d=b", out_valid, in_ready, out_data);
    end
    step();
    n_vec++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL bp_empty: got v=%0b r=%0b want v=0 r=1", out_valid, in_ready);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'h11;
    step();
    in_data = 64'h22;
    step();
    flush   = 1'b1;
    in_data = 64'hC;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    n_vec++;
    if ({out_valid, in_ready, out_data} !== {1'b0, 1'b1, 64'd0}) begin
      n_err++;
      $display("FAIL flush_full: got v=%0b r=%0b d=%0h want v=0 r=1 d=0", out_valid, in_ready, out_data);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++;
      if (out_valid !== 1'b0 || out_data === 64'hC) begin
        n_err++;
        $display("FAIL flush_after_%0d: got v=%0b d=%0h want v=0, never c", i, out_valid, out_data);
      end
    end
  endtask

  task automatic test_priority();
    // rst and flush together with an offered beat: nothing is accepted
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'h77;
    rst       = 1'b1;
    flush     = 1'b1;
    step();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    n_vec++;
    if ({out_valid, in_ready, out_data} !== {1'b0, 1'b1, 64'd0}) begin
      n_err++;
      $display("FAIL rst_flush_prio: got v=%0b r=%0b d=%0h want v=0 r=1 d=0", out_valid, in_ready, out_data);
    end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] q[$];
    int               bad = 0;
    logic             fin, fout;
    logic [WIDTH-1:0] exp_d;
    for (int c = 0; c < 10000; c++) begin
      exp_d = (q.size() > 0) ? q[0] : 64'd0;
      n_vec++;
      if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2) ||
          (q.size() > 0 && out_data !== exp_d)) begin
        n_err++;
        bad++;
        if (bad <= 10)
          $display("FAIL random_c%0d: got v=%0b r=%0b d=%0h want v=%0b r=%0b d=%0h",
                   c, out_valid, in_ready, out_data, q.size() > 0, q.size() < 2, exp_d);
      end
      in_valid  = ($urandom_range(0, 99) < 60);
      out_ready = ($urandom_range(0, 99) < 55);
      in_data   = {$urandom, $urandom};
      fin  = in_valid && (q.size() < 2);
      fout = out_ready && (q.size() > 0);
      step();
      if (fout) void'(q.pop_front());
      if (fin) q.push_back(in_data);
    end
    in_valid = 1'b0;
  endtask

`ifdef PIPELINE_SKID_REG_STATS_EN
  task automatic test_stats();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_vec++;
    if (stall_cycles !== 16'd0) begin
      n_err++;
      $display("FAIL stats_clear: got %0h want 0", stall_cycles);
    end
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'h1;
    step();
    in_valid = 1'b0;
    repeat (70000) step();
    n_vec++;
    if (stall_cycles !== 16'hFFFF) begin
      n_err++;
      $display("FAIL stats_sat: got %0h want ffff", stall_cycles);
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    n_vec++;
    if (stall_cycles !== 16'hFFFF) begin
      n_err++;
      $display("FAIL stats_flush: got %0h want ffff", stall_cycles);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_vec++;
    if (stall_cycles !== 16'd0) begin
      n_err++;
      $display("FAIL stats_rst: got %0h want 0", stall_cycles);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_priority();
    test_random();
`ifdef PIPELINE_SKID_REG_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
